// File: rtl/mips_cpu_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// mips_cpu_writeback_arbiter
//
// Write side of the CPU register file. Two producers compete for the single
// register-file write port:
//   * the single-cycle ALU path, which is never buffered, and
//   * the variable-latency load-response path, which is queued in a small
//     circular FIFO.
// A per-register pending scoreboard tracks outstanding loads so issue logic
// can stall on a destination that has not yet been written back.
//
// Handshake: a transfer happens on a rising edge where valid && ready. Ready
// is derived from registered state only (FIFO occupancy) and never from any
// valid input. A producer keeps valid, reg and data stable until the
// transfer happens.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   alu_valid/alu_reg/alu_data ALU writeback request
//   alu_ready                  ALU request accepted when alu_valid && alu_ready
//   mem_valid/mem_reg/mem_data load response request
//   mem_ready                  load-response FIFO has space
//   claim_valid/claim_reg      load issued; mark its destination pending
//   pending                    bit r set: register r awaits a load result
//   mem_count                  current FIFO occupancy
//   write_enable/write_reg/write_data
//                              registered register-file write port
// ---------------------------------------------------------------------------
module mips_cpu_writeback_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         alu_valid,
    input  logic [4:0]                   alu_reg,
    input  logic [31:0]                  alu_data,
    output logic                         alu_ready,

    input  logic                         mem_valid,
    input  logic [4:0]                   mem_reg,
    input  logic [31:0]                  mem_data,
    output logic                         mem_ready,

    input  logic                         claim_valid,
    input  logic [4:0]                   claim_reg,
    output logic [31:0]                  pending,

    output logic [$clog2(FIFO_DEPTH):0]  mem_count,

    output logic                         write_enable,
    output logic [4:0]                   write_reg,
    output logic [31:0]                  write_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    // -----------------------------------------------------------------------
    // Load-response FIFO storage and pointers
    // -----------------------------------------------------------------------
    logic [4:0]       fifo_reg  [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic alu_take;

    // Marks whether the output register holds a load result; only those
    // retire a pending bit.
    logic out_from_mem;

    logic [31:0] pending_q;
    logic [31:0] pending_next;

    assign fifo_full  = (count_q == FULL_COUNT);
    assign fifo_empty = (count_q == '0);

    // Both producers are throttled by FIFO occupancy alone. A full FIFO
    // stalls the ALU too, so the buffered loads are guaranteed to drain.
    assign mem_ready = !fifo_full;
    assign alu_ready = !fifo_full;

    assign push = mem_valid && mem_ready;

    // Arbitration priority: full FIFO, then ALU, then non-empty FIFO.
    assign pop      = fifo_full || (!alu_valid && !fifo_empty);
    assign alu_take = alu_valid && !fifo_full;

    assign mem_count = count_q;
    assign pending   = pending_q;

    // Storage has no reset: a reset empties the FIFO through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= mem_reg;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output register. Register 0 is consumed like any other destination
    // but never strobes the register file.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            write_enable <= 1'b0;
            write_reg    <= 5'd0;
            write_data   <= 32'd0;
            out_from_mem <= 1'b0;
        end else if (pop) begin
            write_enable <= (fifo_reg[rd_ptr] != 5'd0);
            write_reg    <= fifo_reg[rd_ptr];
            write_data   <= fifo_data[rd_ptr];
            out_from_mem <= 1'b1;
        end else if (alu_take) begin
            write_enable <= (alu_reg != 5'd0);
            write_reg    <= alu_reg;
            write_data   <= alu_data;
            out_from_mem <= 1'b0;
        end else begin
            write_enable <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Pending scoreboard. A load result clears its bit on the edge that ends
    // its write cycle (same edge the register file captures the data). A
    // claim on that same edge belongs to a newer load, so it is applied last
    // and wins.
    // -----------------------------------------------------------------------
    always_comb begin
        pending_next = pending_q;
        if (write_enable && out_from_mem) begin
            pending_next[write_reg] = 1'b0;
        end
        if (claim_valid && (claim_reg != 5'd0)) begin
            pending_next[claim_reg] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 32'd0;
        end else begin
            pending_q <= pending_next;
        end
    end

endmodule

// File: tb/tb_mips_cpu_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mips_cpu_writeback_arbiter.
// A queue-based reference model runs on every rising edge and pushes each
// expected register-file write into exp_q; a monitor on the falling edge
// pops and compares whenever a write is due, and also checks occupancy,
// ready signals and the pending scoreboard. Directed scenarios come first,
// followed by a randomized phase with a mid-run reset.
// ---------------------------------------------------------------------------
module tb_mips_cpu_writeback_arbiter;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        claim_valid;
  logic [4:0]  claim_reg;
  logic [31:0] pending;
  logic [$clog2(DEPTH):0] mem_count;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  mips_cpu_writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_reg      (alu_reg),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_reg      (mem_reg),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .claim_valid  (claim_valid),
    .claim_reg    (claim_reg),
    .pending      (pending),
    .mem_count    (mem_count),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data)
  );

  // ---------------- bookkeeping ----------------
  int tests;
  int fails;
  logic mon_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];            // buffered load responses, oldest first
  logic [36:0] exp_q[$];         // expected writes {reg, data}
  logic [31:0] m_pending;
  logic        m_we;             // a write is expected in the current cycle
  logic        m_retire;         // current write is a load result
  logic [4:0]  m_retire_reg;
  logic        alu_acc;          // ALU request taken at the last edge
  logic        mem_acc;          // load response taken at the last edge

  initial begin
    m_pending = '0;
    m_we = 1'b0;
    m_retire = 1'b0;
    m_retire_reg = '0;
    alu_acc = 1'b0;
    mem_acc = 1'b0;
  end

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      exp_q.delete();
      m_pending = '0;
      m_we = 1'b0;
      m_retire = 1'b0;
      alu_acc = 1'b0;
      mem_acc = 1'b0;
    end else begin
      ent_t e;
      bit full;
      full = (mq.size() == DEPTH);
      // retiring load clears its bit; a claim on the same edge is newer
      if (m_retire) m_pending[m_retire_reg] = 1'b0;
      if (claim_valid && claim_reg != 0) m_pending[claim_reg] = 1'b1;
      m_retire = 1'b0;
      m_we = 1'b0;
      alu_acc = alu_valid && !full;
      mem_acc = mem_valid && !full;
      if (full || (!alu_valid && mq.size() != 0)) begin
        e = mq.pop_front();
        if (e.r != 0) begin
          exp_q.push_back({e.r, e.d});
          m_we = 1'b1;
          m_retire = 1'b1;
          m_retire_reg = e.r;
        end
      end else if (alu_valid) begin
        if (alu_reg != 0) begin
          exp_q.push_back({alu_reg, alu_data});
          m_we = 1'b1;
        end
      end
      if (mem_acc) mq.push_back('{r: mem_reg, d: mem_data});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [36:0] x;
      check("mem_count", 64'(mem_count), 64'(mq.size()));
      check("mem_ready", 64'(mem_ready), 64'(mq.size() != DEPTH));
      check("alu_ready", 64'(alu_ready), 64'(mq.size() != DEPTH));
      check("pending", 64'(pending), 64'(m_pending));
      check("write_enable", 64'(write_enable), 64'(m_we));
      if (m_we && exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check("write_reg", 64'(write_reg), 64'(x[36:32]));
        check("write_data", 64'(write_data), 64'(x[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    claim_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && mq.size() != 0; i++) cyc();
    cyc();
    check("drained", 64'(mem_count), 64'd0);
  endtask

  task automatic check_reset_values();
    check("rst_we", 64'(write_enable), 64'd0);
    check("rst_reg", 64'(write_reg), 64'd0);
    check("rst_data", 64'(write_data), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_count", 64'(mem_count), 64'd0);
    check("rst_mem_ready", 64'(mem_ready), 64'd1);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
  endtask

  task automatic drive_random(input int alu_pct, input int mem_pct);
    if (!(alu_valid && !alu_acc)) begin
      alu_valid = ($urandom_range(0, 99) < alu_pct);
      alu_reg = 5'($urandom_range(0, 31));
      alu_data = $urandom;
    end
    if (!(mem_valid && !mem_acc)) begin
      mem_valid = ($urandom_range(0, 99) < mem_pct);
      mem_reg = 5'($urandom_range(0, 31));
      mem_data = $urandom;
    end
    claim_valid = ($urandom_range(0, 99) < 20);
    claim_reg = 5'($urandom_range(0, 31));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    tests = 0;
    fails = 0;
    mon_en = 1'b0;
    reset = 1'b1;
    idle_inputs();
    alu_reg = '0; alu_data = '0;
    mem_reg = '0; mem_data = '0;
    claim_reg = '0;
    repeat (2) cyc();
    reset = 1'b0;
    mon_en = 1'b1;
    check_reset_values();

    // ALU write reg 5
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    cyc();
    alu_valid = 1'b0;
    check("alu_we", 64'(write_enable), 64'd1);
    check("alu_reg", 64'(write_reg), 64'd5);
    check("alu_data", 64'(write_data), 64'hDEADBEEF);
    cyc();
    check("alu_we_drop", 64'(write_enable), 64'd0);

    // ALU write to register 0 is consumed silently
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h1234;
    check("r0_ready", 64'(alu_ready), 64'd1);
    cyc();
    alu_valid = 1'b0;
    check("r0_we", 64'(write_enable), 64'd0);
    cyc();
    check("r0_we2", 64'(write_enable), 64'd0);

    // claim reg 8, then its load result
    claim_valid = 1'b1; claim_reg = 5'd8;
    cyc();
    claim_valid = 1'b0;
    check("claim8", 64'(pending[8]), 64'd1);
    mem_valid = 1'b1; mem_reg = 5'd8; mem_data = 32'hCAFE0001;
    cyc();
    mem_valid = 1'b0;
    check("ld8_not_yet", 64'(write_enable), 64'd0);
    cyc();
    check("ld8_we", 64'(write_enable), 64'd1);
    check("ld8_reg", 64'(write_reg), 64'd8);
    check("ld8_data", 64'(write_data), 64'hCAFE0001);
    check("ld8_pend_held", 64'(pending[8]), 64'd1);
    cyc();
    check("ld8_pend_clr", 64'(pending[8]), 64'd0);

    // ALU busy while four loads arrive: FIFO fills, then drains in order
    alu_valid = 1'b1; alu_reg = 5'd20; alu_data = $urandom;
    for (int i = 1; i <= 4; i++) begin
      mem_valid = 1'b1; mem_reg = 5'(i); mem_data = 32'hA0000000 + i;
      cyc();
      alu_data = $urandom;
    end
    mem_valid = 1'b0;
    check("full_count", 64'(mem_count), 64'd4);
    check("full_mem_ready", 64'(mem_ready), 64'd0);
    check("full_alu_ready", 64'(alu_ready), 64'd0);
    repeat (3) cyc();
    alu_valid = 1'b0;
    drain();

    // steady push+pop at occupancy 2 across pointer wrap
    alu_valid = 1'b1; alu_reg = 5'd22; alu_data = 32'h22220000;
    for (int i = 0; i < 2; i++) begin
      mem_valid = 1'b1; mem_reg = 5'(10 + i); mem_data = 32'hB0000000 + i;
      cyc();
    end
    alu_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mem_reg = 5'(12 + i); mem_data = 32'hB1000000 + i;
      cyc();
      check("steady_count", 64'(mem_count), 64'd2);
    end
    mem_valid = 1'b0;
    drain();

    // claim reg 9 on the edge its earlier load retires: set wins
    claim_valid = 1'b1; claim_reg = 5'd9;
    cyc();
    claim_valid = 1'b0;
    mem_valid = 1'b1; mem_reg = 5'd9; mem_data = 32'h99990000;
    cyc();
    mem_valid = 1'b0;
    cyc();
    claim_valid = 1'b1; claim_reg = 5'd9;
    cyc();
    claim_valid = 1'b0;
    check("set_wins", 64'(pending[9]), 64'd1);
    repeat (2) cyc();
    check("set_wins_hold", 64'(pending[9]), 64'd1);

    // reset with three responses buffered
    alu_valid = 1'b1; alu_reg = 5'd21; alu_data = 32'h21212121;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_reg = 5'(13 + i); mem_data = 32'hC0000000 + i;
      cyc();
    end
    mem_valid = 1'b0;
    check("pre_reset_count", 64'(mem_count), 64'd3);
    reset = 1'b1;
    alu_valid = 1'b0;
    cyc();
    reset = 1'b0;
    check_reset_values();
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("post_reset_we", 64'(write_enable), 64'd0);
    end

    // randomized traffic, with a reset in the middle
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) begin
        reset = 1'b1;
        idle_inputs();
      end else begin
        reset = 1'b0;
        drive_random((c < 1000) ? 80 : 40, 45);
      end
      cyc();
    end
    reset = 1'b0;
    idle_inputs();
    drain();
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_cpu_writeback_arbiter.md
# mips_cpu_writeback_arbiter

Write side of the CPU register file. Collects register writeback requests from two producers: the single-cycle ALU path, and the variable-latency memory/load response path. Arbitrates them onto the register file's single write port (`write_enable` / `write_reg` / `write_data`). Also keeps a per-register pending scoreboard so issue logic can stall on outstanding loads.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: memory-response buffer depth; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU writeback request.
- `alu_reg`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle when `alu_valid && alu_ready`.
- `mem_valid`  in  1  load response request.
- `mem_reg`  in  5  load destination register.
- `mem_data`  in  32  load data.
- `mem_ready`  out  1  FIFO has space.
- `claim_valid`  in  1  load issued; mark its destination as pending.
- `claim_reg`  in  5  register to mark pending.
- `pending`  out  32  scoreboard; bit r set means register r awaits a load result.
- `mem_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `write_enable`  out  1  register file write strobe (registered).
- `write_reg`  out  5  register file write address (registered).
- `write_data`  out  32  register file write data (registered).

## Operation
- Memory path:
  - A response is pushed into the FIFO when `mem_valid && mem_ready`.
  - `mem_ready = (mem_count != FIFO_DEPTH)`; it depends on the count only, with no same-cycle pop-through.
- ALU path:
  - `alu_ready = (mem_count != FIFO_DEPTH)`.
  - An accepted ALU request goes straight to the output register; it is never buffered.
- Arbitration, evaluated each cycle:
  - FIFO full: pop the FIFO head to the output; ALU is stalled.
  - Otherwise, if `alu_valid`: the ALU wins; the FIFO holds.
  - Otherwise, if FIFO non-empty: pop the FIFO head.
  - Otherwise: output idle.
- Output register:
  - On the edge after a selection, `write_enable <= (selected_reg != 0)`, `write_reg <= selected_reg`, `write_data <= selected_data`.
  - With no selection, `write_enable <= 0`; `write_reg` and `write_data` hold.
  - Register 0: the request is consumed normally but `write_enable` stays 0.
- Output register source tag: a 1-bit internal flag marks whether the output register holds an ALU or a memory entry.
- Scoreboard:
  - `claim_valid` with `claim_reg != 0` sets `pending[claim_reg]`. `pending[0]` is constantly 0.
  - A memory-sourced write clears `pending[write_reg]` on the edge ending its `write_enable` cycle. This is the same edge on which the register file captures the data.
  - ALU writes never modify `pending`.
  - Set and clear of the same register on the same edge: set wins, because a newer load has been issued.
- FIFO:
  - Circular buffer with read/write pointers of width $clog2(FIFO_DEPTH); pointers wrap modulo `FIFO_DEPTH`.
  - Simultaneous push and pop leaves `mem_count` unchanged. Pop of an empty FIFO never occurs.

## Timing
- Reset values: `write_enable`=0, `write_reg`=0, `write_data`=0, `pending`=0, `mem_count`=0, pointers 0.
  - Therefore `mem_ready`=1 and `alu_ready`=1 in the first cycle after reset.
  - Reset mid-operation discards all buffered responses and pending bits within one edge.
- ALU latency: accepted at edge N → `write_enable` high during cycle N to N+1, one cycle.
- Memory latency: pushed at edge N into an empty FIFO with ALU idle → popped at edge N+1 → `write_enable` high during cycle N+1 to N+2; `pending` bit falls at edge N+2.
- Throughput: one write per cycle total. The FIFO drains at one entry per cycle whenever the ALU is idle or the FIFO is full.
- Ready signals are valid combinationally from registered state only, with no path from any `*_valid` input.
- Producers must hold `*_valid`, `*_reg` and `*_data` stable until accepted.

## Test plan
- Reset, then `alu_valid`=1, `alu_reg`=5, `alu_data`=0xDEADBEEF for one cycle → next cycle `write_enable`=1, `write_reg`=5, `write_data`=0xDEADBEEF; following cycle `write_enable`=0.
- ALU request with `alu_reg`=0, data 0x1234 → `alu_ready`=1 and the request is consumed, `write_enable` stays 0 throughout.
- `claim_valid` reg 8, then a memory response reg 8 / 0xCAFE0001 with ALU idle → `pending[8]`=1 after the claim; write of 0xCAFE0001 two cycles after the push; `pending[8]`=0 on the edge after that.
- ALU valid continuously while 4 memory responses (regs 1 to 4) arrive → FIFO fills (`mem_count`=4, `mem_ready`=0, `alu_ready`=0). The FIFO then drains regs 1 to 4 in order, ALU writes resume, and no entry is lost or duplicated.
- Simultaneous push and pop with `mem_count`=2, including pointer wrap past index 3 → `mem_count` stays 2 and data order is preserved.
- Claim reg 9 issued on the same edge that a memory write to reg 9 retires → `pending[9]` remains 1. Then assert reset with 3 entries buffered → all outputs return to reset values and no further writes occur.
